bcd_sseg_mux_amisha: RTL and testbench
======================================

Name: bcd_sseg_mux_amisha

Overview:
- Downstream consumer of the 13-bit binary-to-BCD converter.
- Captures the four BCD digits on the converter's done tick and holds them.
- Drives a 4-digit common-anode seven-segment display by time-multiplexing. A free-running refresh counter scans the digits.
- Blanks the display from reset until the first conversion result arrives.

Parameters:
- N, 18, refresh counter width. Each digit is lit for 2^(N-2) cycles; a full scan is 2^N cycles. N must be at least 3.

Ports:
- clk_amisha  input  1  system clock, rising edge
- reset_amisha  input  1  asynchronous reset, active-high
- done_tick_amisha  input  1  one-cycle capture strobe from the converter
- bcd3_amisha  input  4  thousands digit
- bcd2_amisha  input  4  hundreds digit
- bcd1_amisha  input  4  tens digit
- bcd0_amisha  input  4  units digit
- dp_amisha  input  4  live decimal-point enables, active-high, bit i belongs to digit i
- an_amisha  output  4  digit anodes, active-low, bit i belongs to digit i
- sseg_amisha  output  8  segments, active-low, {dp,g,f,e,d,c,b,a}
- disp_valid_amisha  output  1  high once a value has been captured

Behaviour:
- Reset is asynchronous and active-high: one clock, clk_amisha, with reset_amisha asynchronous active-high.
- Reset values:
  - an_amisha = 4'b1111
  - sseg_amisha = 8'hFF
  - disp_valid_amisha = 0
  - refresh counter = 0
  - digit latches = 0
  - state = BLANK
- Refresh counter q:
  - N bits, increments every cycle, wraps from 2^N-1 to 0.
  - Never reset by done_tick.
  - sel = q[N-1:N-2]. sel 0..3 selects digit 0..3; anode pattern is 1110, 1101, 1011, 0111.
- State machine:
  - BLANK: an=1111, sseg=FF. On done_tick, latch the four digits and go to SHOW.
  - SHOW: display the latched digits. On done_tick, re-latch the digits and stay in SHOW.
  - No other transitions out of SHOW except reset.
  - Undefined state encodings return to BLANK.
- Latency:
  - an/sseg are registered. Outputs in cycle t+1 reflect sel, the latched digits and dp_amisha sampled in cycle t.
  - A done_tick in cycle t latches digits at edge t. The new value is visible on the outputs at edge t+1 for whichever digit is selected.
  - disp_valid_amisha rises at the same edge the first latch occurs and stays high until reset.
- Segment decode, active-low with dp bit = 1:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99
  - 5=92, 6=82, 7=F8, 8=80, 9=90
- Boundary cases:
  - Digit values 10..15 are illegal BCD. They display a dash (BF); no error flag.
  - dp: sseg[7] = ~dp_amisha[sel], applied after decode. It is applied to dash digits too. It is suppressed for blanked digits.
  - done_tick held high for several cycles re-latches every cycle; the last value wins.
  - Input digits are ignored while done_tick is low.
  - Reset mid-scan: outputs go to reset values immediately (asynchronously). After release, the first lit cycle is digit 0, one edge later, and only once a capture has occurred.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN
- When defined:
  - Digit 3 is blanked if d3==0.
  - Digit 2 is blanked if d3==0 and d2==0.
  - Digit 1 is blanked if d3, d2 and d1 are all 0.
  - Digit 0 is never blanked.
  - A blanked digit drives anode 1 and sseg FF for its slot, including dp. Scan timing is unchanged.
  - A dash digit (value above 9) counts as non-zero.
- When undefined: all four digits are always lit in SHOW, zeros included.

Test Plan (N=4, 4 cycles per digit):
- Reset, no done_tick for 64 cycles -> an=1111, sseg=FF, disp_valid=0 throughout.
- done_tick with digits 8,1,9,2 -> from the next edge, slot sel0 shows an=1110/sseg=A4, sel1 1101/90, sel2 1011/F9, sel3 0111/80; disp_valid=1.
- Capture 0,0,4,7. Without the macro, digits 3 and 2 show C0. With the macro, an stays 1 in slots 3 and 2, and slots 1 and 0 show 99 and F8.
- Capture digit0=12, dp_amisha=4'b0001 -> slot 0 shows sseg=3F (dash with dp lit); other slots have bit7=1.
- Second done_tick mid-slot changing digit0 5->6 -> sseg changes 92->82 exactly one edge after the tick; anode sequence is uninterrupted.
- Assert reset during slot 2 -> an=1111, sseg=FF and disp_valid=0 immediately. After release, BLANK until the next done_tick.

Source files
------------

// File: rtl/bcd_sseg_mux_amisha_if.sv
// Bundle between the BCD converter side and the seven-segment display mux.
// The master drives the capture strobe, digits and decimal points.
// The slave (the display mux) drives the anodes, segments and valid flag.
interface bcd_sseg_mux_amisha_if;
    logic       done_tick_amisha;
    logic [3:0] bcd3_amisha;
    logic [3:0] bcd2_amisha;
    logic [3:0] bcd1_amisha;
    logic [3:0] bcd0_amisha;
    logic [3:0] dp_amisha;
    logic [3:0] an_amisha;
    logic [7:0] sseg_amisha;
    logic       disp_valid_amisha;

    modport master (
        output done_tick_amisha,
        output bcd3_amisha,
        output bcd2_amisha,
        output bcd1_amisha,
        output bcd0_amisha,
        output dp_amisha,
        input  an_amisha,
        input  sseg_amisha,
        input  disp_valid_amisha
    );

    modport slave (
        input  done_tick_amisha,
        input  bcd3_amisha,
        input  bcd2_amisha,
        input  bcd1_amisha,
        input  bcd0_amisha,
        input  dp_amisha,
        output an_amisha,
        output sseg_amisha,
        output disp_valid_amisha
    );
endinterface

// File: rtl/bcd_sseg_mux_amisha.sv
// Four-digit common-anode seven-segment display multiplexer.
// Latches BCD digits on the converter's done tick and scans them with a
// free-running refresh counter; the display stays blank until the first capture.
// Optional build macro: LEADING_ZERO_BLANK_EN (blank leading zeros of digits 3..1).
module bcd_sseg_mux_amisha #(
    parameter int N = 18
) (
    input  logic                     clk_amisha,
    input  logic                     reset_amisha,
    bcd_sseg_mux_amisha_if.slave     bus
);

    typedef enum logic [1:0] {
        BLANK = 2'b00,
        SHOW  = 2'b01
    } state_t;

    localparam logic [N-1:0] CNT_ONE = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0] q_q, q_d;
    state_t       state_q, state_d;
    logic [3:0]   dig_q [4];
    logic [3:0]   dig_d [4];
    logic [3:0]   dig_in [4];
    logic         valid_q, valid_d;
    logic [3:0]   an_q, an_d;
    logic [7:0]   sseg_q, sseg_d;
    logic [1:0]   sel;
    logic [3:0]   lit;

    // Active-low segment pattern {dp,g,f,e,d,c,b,a} with dp off; non-BCD shows a dash.
    function automatic logic [7:0] seg_decode(input logic [3:0] v);
        logic [7:0] s;
        case (v)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hBF;
        endcase
        return s;
    endfunction

    assign dig_in[0] = bus.bcd0_amisha;
    assign dig_in[1] = bus.bcd1_amisha;
    assign dig_in[2] = bus.bcd2_amisha;
    assign dig_in[3] = bus.bcd3_amisha;

    assign sel = q_q[N-1 -: 2];

    // Free-running refresh counter; only reset clears it.
    always_comb begin
        q_d = q_q + CNT_ONE;
    end

    // Capture FSM: leaves BLANK on the first done tick, re-latches on every tick.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        for (int i = 0; i < 4; i++) begin
            dig_d[i] = dig_q[i];
        end
        if (bus.done_tick_amisha) begin
            for (int i = 0; i < 4; i++) begin
                dig_d[i] = dig_in[i];
            end
            valid_d = 1'b1;
        end
        case (state_q)
            BLANK:   if (bus.done_tick_amisha) state_d = SHOW;
            SHOW:    state_d = SHOW;
            default: state_d = BLANK;
        endcase
    end

    // Which digit slots are lit (leading-zero suppression when enabled).
`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        lit    = 4'b0001;
        lit[3] = (dig_q[3] != 4'd0);
        lit[2] = (dig_q[3] != 4'd0) || (dig_q[2] != 4'd0);
        lit[1] = (dig_q[3] != 4'd0) || (dig_q[2] != 4'd0) || (dig_q[1] != 4'd0);
    end
`else
    always_comb begin
        lit = 4'b1111;
    end
`endif

    // Next anode/segment drive for the slot selected this cycle.
    always_comb begin
        an_d   = 4'b1111;
        sseg_d = 8'hFF;
        if ((state_q == SHOW) && lit[sel]) begin
            an_d      = ~(4'b0001 << sel);
            sseg_d    = seg_decode(dig_q[sel]);
            sseg_d[7] = ~bus.dp_amisha[sel];
        end
    end

    // State, latches and registered display outputs.
    always_ff @(posedge clk_amisha or posedge reset_amisha) begin
        if (reset_amisha) begin
            q_q     <= '0;
            state_q <= BLANK;
            valid_q <= 1'b0;
            an_q    <= 4'b1111;
            sseg_q  <= 8'hFF;
            for (int i = 0; i < 4; i++) begin
                dig_q[i] <= 4'd0;
            end
        end else begin
            q_q     <= q_d;
            state_q <= state_d;
            valid_q <= valid_d;
            an_q    <= an_d;
            sseg_q  <= sseg_d;
            for (int i = 0; i < 4; i++) begin
                dig_q[i] <= dig_d[i];
            end
        end
    end

    assign bus.an_amisha         = an_q;
    assign bus.sseg_amisha       = sseg_q;
    assign bus.disp_valid_amisha = valid_q;

endmodule

// File: tb/tb_bcd_sseg_mux_amisha.sv
// Directed testbench for bcd_sseg_mux_amisha with N=4 (4 cycles per digit slot).
module tb_bcd_sseg_mux_amisha;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   edges    = 0;

    bcd_sseg_mux_amisha_if bus();

    bcd_sseg_mux_amisha #(.N(4)) dut (
        .clk_amisha   (clk),
        .reset_amisha (rst),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    // Edges since reset release; output at edge k reflects scan position k-1.
    always @(posedge clk or posedge rst) begin
        if (rst) edges <= 0;
        else     edges <= edges + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    function automatic int scan_pos();
        return (edges + 15) % 16;
    endfunction

    // Check one full 16-cycle scan; s0..s3 are expected segments of lit slots.
    task automatic scan_check(input string tag, input logic [3:0] lit_mask,
                              input logic [7:0] s0, input logic [7:0] s1,
                              input logic [7:0] s2, input logic [7:0] s3,
                              input logic exp_valid);
        logic [7:0] segs [4];
        logic [3:0] exp_an;
        logic [7:0] exp_seg;
        int sel;
        segs[0] = s0; segs[1] = s1; segs[2] = s2; segs[3] = s3;
        for (int i = 0; i < 16; i++) begin
            sel = scan_pos() / 4;
            if (lit_mask[sel]) begin
                exp_an  = ~(4'b0001 << sel);
                exp_seg = segs[sel];
            end else begin
                exp_an  = 4'b1111;
                exp_seg = 8'hFF;
            end
            check_eq($sformatf("%s an sel%0d", tag, sel), 32'(bus.an_amisha), 32'(exp_an));
            check_eq($sformatf("%s sseg sel%0d", tag, sel), 32'(bus.sseg_amisha), 32'(exp_seg));
            check_eq($sformatf("%s valid", tag), 32'(bus.disp_valid_amisha), 32'(exp_valid));
            @(negedge clk);
        end
    endtask

    // Pulse done_tick for one cycle with the given digits; returns at the
    // first negedge whose outputs reflect the new latch.
    task automatic capture(input logic [3:0] d3, input logic [3:0] d2,
                           input logic [3:0] d1, input logic [3:0] d0);
        bus.bcd3_amisha = d3; bus.bcd2_amisha = d2;
        bus.bcd1_amisha = d1; bus.bcd0_amisha = d0;
        bus.done_tick_amisha = 1'b1;
        @(negedge clk);
        bus.done_tick_amisha = 1'b0;
        bus.bcd3_amisha = 4'hF; bus.bcd2_amisha = 4'hF;
        bus.bcd1_amisha = 4'hF; bus.bcd0_amisha = 4'hF;
        check_eq("valid after latch", 32'(bus.disp_valid_amisha), 32'd1);
        @(negedge clk);
    endtask

    // Advance to the negedge where the displayed scan position equals pos.
    task automatic wait_pos(input int pos);
        int guard = 0;
        while (scan_pos() != pos && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check_eq($sformatf("reached scan pos %0d", pos), 32'(scan_pos()), 32'(pos));
    endtask

    localparam logic [3:0] LIT_ALL = 4'b1111;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [3:0] LIT_0047 = 4'b0011;
`else
    localparam logic [3:0] LIT_0047 = 4'b1111;
`endif

    initial begin
        bus.done_tick_amisha = 1'b0;
        bus.bcd3_amisha = 4'd0; bus.bcd2_amisha = 4'd0;
        bus.bcd1_amisha = 4'd0; bus.bcd0_amisha = 4'd0;
        bus.dp_amisha   = 4'b0000;

        // Reset state while reset is held.
        repeat (3) @(negedge clk);
        check_eq("reset an", 32'(bus.an_amisha), 32'hF);
        check_eq("reset sseg", 32'(bus.sseg_amisha), 32'hFF);
        check_eq("reset valid", 32'(bus.disp_valid_amisha), 32'd0);
        rst = 1'b0;

        // No capture yet: blank for 64 cycles.
        @(negedge clk);
        for (int k = 0; k < 4; k++) scan_check("blank", 4'b0000, 8'h0, 8'h0, 8'h0, 8'h0, 1'b0);

        // Digits 8,1,9,2.
        capture(4'd8, 4'd1, 4'd9, 4'd2);
        scan_check("8192", LIT_ALL, 8'hA4, 8'h90, 8'hF9, 8'h80, 1'b1);

        // Digits 0,0,4,7 (leading zeros).
        capture(4'd0, 4'd0, 4'd4, 4'd7);
        scan_check("0047", LIT_0047, 8'hF8, 8'h99, 8'hC0, 8'hC0, 1'b1);

        // Illegal digit 12 in slot 0 with its decimal point lit.
        bus.dp_amisha = 4'b0001;
        capture(4'd3, 4'd2, 4'd1, 4'd12);
        scan_check("dash_dp", LIT_ALL, 8'h3F, 8'hF9, 8'hA4, 8'hB0, 1'b1);
        bus.dp_amisha = 4'b0000;

        // Mid-slot re-capture: digit0 5 -> 6 changes one edge after the tick.
        capture(4'd1, 4'd2, 4'd3, 4'd5);
        wait_pos(1);
        check_eq("mid an pos1", 32'(bus.an_amisha), 32'hE);
        check_eq("mid sseg pos1", 32'(bus.sseg_amisha), 32'h92);
        bus.bcd3_amisha = 4'd1; bus.bcd2_amisha = 4'd2;
        bus.bcd1_amisha = 4'd3; bus.bcd0_amisha = 4'd6;
        bus.done_tick_amisha = 1'b1;
        @(negedge clk);
        bus.done_tick_amisha = 1'b0;
        check_eq("mid an latch edge", 32'(bus.an_amisha), 32'hE);
        check_eq("mid sseg latch edge", 32'(bus.sseg_amisha), 32'h92);
        @(negedge clk);
        check_eq("mid an next edge", 32'(bus.an_amisha), 32'hE);
        check_eq("mid sseg next edge", 32'(bus.sseg_amisha), 32'h82);
        @(negedge clk);
        scan_check("1236", LIT_ALL, 8'h82, 8'hB0, 8'hA4, 8'hF9, 1'b1);

        // Asynchronous reset during slot 2.
        wait_pos(9);
        check_eq("pre-reset an slot2", 32'(bus.an_amisha), 32'hB);
        rst = 1'b1;
        #1;
        check_eq("async reset an", 32'(bus.an_amisha), 32'hF);
        check_eq("async reset sseg", 32'(bus.sseg_amisha), 32'hFF);
        check_eq("async reset valid", 32'(bus.disp_valid_amisha), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        scan_check("post-reset blank", 4'b0000, 8'h0, 8'h0, 8'h0, 8'h0, 1'b0);

        // Capture after reset; first lit slot follows the counter from zero.
        capture(4'd9, 4'd8, 4'd7, 4'd6);
        scan_check("9876", LIT_ALL, 8'h82, 8'hF8, 8'h80, 8'h90, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
